// File: rtl/daq_pkg.sv
// Shared definitions for the ADC sample acquisition path.
// Holds the sample/count widths used by both the threshold sampler and the
// readout, the default packet sync byte, the readout FSM state codes and
// the helpers that split a 10-bit sample into its two link bytes.
package daq_pkg;

  localparam int SAMPLE_W = 10;
  localparam int CNT_W    = 16;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  // Readout FSM state codes
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_HDR  = 3'd1;
  localparam logic [2:0] ST_SEQ  = 3'd2;
  localparam logic [2:0] ST_RD   = 3'd3;
  localparam logic [2:0] ST_WAIT = 3'd4;
  localparam logic [2:0] ST_HI   = 3'd5;
  localparam logic [2:0] ST_LO   = 3'd6;
  localparam logic [2:0] ST_CSUM = 3'd7;

  // High link byte of a sample: the two MSBs, zero padded
  function automatic logic [7:0] sample_hi_byte(input logic [SAMPLE_W-1:0] s);
    return {6'b000000, s[9:8]};
  endfunction

  // Low link byte of a sample
  function automatic logic [7:0] sample_lo_byte(input logic [SAMPLE_W-1:0] s);
    return s[7:0];
  endfunction

endpackage

// File: rtl/readout_byte_reg.sv
// Output byte register of the sample readout.
// Holds tx_data/tx_valid stable until the link accepts the byte.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   load, load_data     present a new byte (takes priority over acceptance,
//                       so a byte accepted and replaced on the same edge
//                       keeps tx_valid high for back-to-back transfer)
//   tx_ready            link accepts when tx_valid & tx_ready
//   tx_data, tx_valid   registered byte and its valid flag
module readout_byte_reg (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid
);

  logic [7:0] data_r;
  logic       valid_r;

  // Byte/valid register: load a new byte, drop valid on acceptance, else hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r  <= 8'h00;
      valid_r <= 1'b0;
    end else if (load) begin
      data_r  <= load_data;
      valid_r <= 1'b1;
    end else if (valid_r && tx_ready) begin
      valid_r <= 1'b0;
    end else begin
      data_r  <= data_r;
      valid_r <= valid_r;
    end
  end

  assign tx_data  = data_r;
  assign tx_valid = valid_r;

endmodule

// File: rtl/sample_readout.sv
// Reader side of the ADC sample buffer.
// Drains PKT_SAMPLES 10-bit samples from the sample FIFO and frames them as
//   SYNC, seq, {hi,lo} x PKT_SAMPLES, csum
// over a valid/ready byte link. csum is the XOR of seq and all sample bytes.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   fifo_dout     FIFO read data, valid RD_LATENCY cycles after fifo_rd_en
//   fifo_count    FIFO occupancy, only looked at while idle
//   fifo_rd_en    one-cycle read strobe per sample
//   tx_data/tx_valid/tx_ready  byte link handshake
//   busy          packet in progress
//   pkt_count     packets completed since reset (wrapping)
module sample_readout
  import daq_pkg::*;
#(
  parameter int unsigned PKT_SAMPLES = 16,
  parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEF,
  parameter int unsigned RD_LATENCY  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SAMPLE_W-1:0] fifo_dout,
  input  logic [CNT_W-1:0]    fifo_count,
  output logic                fifo_rd_en,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic                busy,
  output logic [CNT_W-1:0]    pkt_count
);

  localparam logic [CNT_W-1:0] PKT_THRESH = CNT_W'(PKT_SAMPLES);
  localparam logic [7:0]       LAST_IDX   = 8'(PKT_SAMPLES - 1);
  localparam logic [1:0]       WAIT_LAST  = 2'(RD_LATENCY - 1);

  logic [2:0]          state_r, state_nxt_s;
  logic [7:0]          seq_r, seq_nxt_s;
  logic [7:0]          csum_r, csum_nxt_s;
  logic [7:0]          smp_cnt_r, smp_cnt_nxt_s;
  logic [1:0]          wait_cnt_r, wait_cnt_nxt_s;
  logic [SAMPLE_W-1:0] sample_r, sample_nxt_s;
  logic [CNT_W-1:0]    pkt_count_r, pkt_nxt_s;
  logic                rd_en_r;
  logic                busy_r;
  logic                load_s;
  logic [7:0]          load_data_s;
  logic                accept_s;

  assign accept_s = tx_valid & tx_ready;

  // Next-state, byte selection and running checksum.
  // The checksum is folded in as each byte is loaded, so by the time the
  // last LO byte is accepted csum_r already covers it.
  always_comb begin
    state_nxt_s    = state_r;
    seq_nxt_s      = seq_r;
    csum_nxt_s     = csum_r;
    smp_cnt_nxt_s  = smp_cnt_r;
    wait_cnt_nxt_s = wait_cnt_r;
    sample_nxt_s   = sample_r;
    pkt_nxt_s      = pkt_count_r;
    load_s         = 1'b0;
    load_data_s    = 8'h00;
    case (state_r)
      ST_IDLE: begin
        if (fifo_count >= PKT_THRESH) begin
          state_nxt_s = ST_HDR;
          load_s      = 1'b1;
          load_data_s = SYNC_BYTE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_HDR: begin
        if (accept_s) begin
          state_nxt_s   = ST_SEQ;
          smp_cnt_nxt_s = 8'd0;
          csum_nxt_s    = seq_r;
          load_s        = 1'b1;
          load_data_s   = seq_r;
        end else begin
          state_nxt_s = ST_HDR;
        end
      end
      ST_SEQ: begin
        if (accept_s) begin
          state_nxt_s = ST_RD;
        end else begin
          state_nxt_s = ST_SEQ;
        end
      end
      ST_RD: begin
        state_nxt_s    = ST_WAIT;
        wait_cnt_nxt_s = 2'd0;
      end
      ST_WAIT: begin
        if (wait_cnt_r == WAIT_LAST) begin
          state_nxt_s  = ST_HI;
          sample_nxt_s = fifo_dout;
          load_s       = 1'b1;
          load_data_s  = sample_hi_byte(fifo_dout);
          csum_nxt_s   = csum_r ^ sample_hi_byte(fifo_dout);
        end else begin
          wait_cnt_nxt_s = wait_cnt_r + 2'd1;
        end
      end
      ST_HI: begin
        if (accept_s) begin
          state_nxt_s = ST_LO;
          load_s      = 1'b1;
          load_data_s = sample_lo_byte(sample_r);
          csum_nxt_s  = csum_r ^ sample_lo_byte(sample_r);
        end else begin
          state_nxt_s = ST_HI;
        end
      end
      ST_LO: begin
        if (accept_s) begin
          if (smp_cnt_r == LAST_IDX) begin
            state_nxt_s = ST_CSUM;
            load_s      = 1'b1;
            load_data_s = csum_r;
          end else begin
            state_nxt_s   = ST_RD;
            smp_cnt_nxt_s = smp_cnt_r + 8'd1;
          end
        end else begin
          state_nxt_s = ST_LO;
        end
      end
      ST_CSUM: begin
        if (accept_s) begin
          state_nxt_s = ST_IDLE;
          seq_nxt_s   = seq_r + 8'd1;
          pkt_nxt_s   = pkt_count_r + 16'd1;
        end else begin
          state_nxt_s = ST_CSUM;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM state, packet bookkeeping and registered strobes.
  // rd_en/busy are computed from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      seq_r       <= 8'h00;
      csum_r      <= 8'h00;
      smp_cnt_r   <= 8'h00;
      wait_cnt_r  <= 2'd0;
      sample_r    <= {SAMPLE_W{1'b0}};
      pkt_count_r <= 16'h0000;
      rd_en_r     <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      seq_r       <= seq_nxt_s;
      csum_r      <= csum_nxt_s;
      smp_cnt_r   <= smp_cnt_nxt_s;
      wait_cnt_r  <= wait_cnt_nxt_s;
      sample_r    <= sample_nxt_s;
      pkt_count_r <= pkt_nxt_s;
      rd_en_r     <= (state_nxt_s == ST_RD);
      busy_r      <= (state_nxt_s != ST_IDLE);
    end
  end

  readout_byte_reg u_byte_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load_s),
    .load_data (load_data_s),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid)
  );

  assign fifo_rd_en = rd_en_r;
  assign busy       = busy_r;
  assign pkt_count  = pkt_count_r;

endmodule

// File: tb/tb_sample_readout.sv
module tb_sample_readout;

  localparam int N       = 2;
  localparam int PKT_LEN = 3 + 2 * N;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  fifo_dout;
  logic [15:0] fifo_count;
  logic        fifo_rd_en;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic [15:0] pkt_count;

  int n_cmp = 0;
  int n_err = 0;

  logic [9:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int         wr_total = 0;
  int         rd_total = 0;
  int         pos = 0;
  int         exp_pkt = 0;
  int         rd_pulses = 0;
  int         ready_mode = 0;
  logic       manual_ready = 1'b1;
  logic [7:0] model_seq = 8'h00;

  // Hand-computed packets. 0x065 has bits[9:8]=0, so its high byte is 0x00.
  // csum = seq ^ 03 ^ FF ^ 00 ^ 65
  logic [7:0] lit_p0 [PKT_LEN] = '{8'hA5, 8'h00, 8'h03, 8'hFF, 8'h00, 8'h65, 8'h99};
  logic [7:0] lit_p1 [PKT_LEN] = '{8'hA5, 8'h01, 8'h03, 8'hFF, 8'h00, 8'h65, 8'h98};
  // samples 0x2C4, 0x0F0 with seq 0: 00^02^C4^00^F0 = 36
  logic [7:0] lit_p2 [PKT_LEN] = '{8'hA5, 8'h00, 8'h02, 8'hC4, 8'h00, 8'hF0, 8'h36};

  assign fifo_count = 16'(wr_total - rd_total);

  always #5 clk = ~clk;

  sample_readout #(
    .PKT_SAMPLES (N),
    .SYNC_BYTE   (8'hA5),
    .RD_LATENCY  (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_dout  (fifo_dout),
    .fifo_count (fifo_count),
    .fifo_rd_en (fifo_rd_en),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .pkt_count  (pkt_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a packet is SYNC, seq, hi/lo per sample, XOR of everything but SYNC
  task automatic expect_packet(input logic [9:0] s0, input logic [9:0] s1);
    logic [9:0] s [2];
    logic [7:0] c;
    s[0] = s0;
    s[1] = s1;
    c = model_seq;
    exp_q.push_back(8'hA5);
    exp_q.push_back(model_seq);
    for (int i = 0; i < N; i++) begin
      exp_q.push_back({6'b000000, s[i][9:8]});
      exp_q.push_back(s[i][7:0]);
      c = c ^ {6'b000000, s[i][9:8]} ^ s[i][7:0];
    end
    exp_q.push_back(c);
    model_seq = model_seq + 8'd1;
  endtask

  task automatic expect_literal(input int which);
    for (int i = 0; i < PKT_LEN; i++) begin
      case (which)
        0: exp_q.push_back(lit_p0[i]);
        1: exp_q.push_back(lit_p1[i]);
        default: exp_q.push_back(lit_p2[i]);
      endcase
    end
    model_seq = model_seq + 8'd1;
  endtask

  task automatic push_sample(input logic [9:0] v);
    fifo_q.push_back(v);
    wr_total++;
  endtask

  task automatic wait_done(input string name);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && !busy) begin
        done = 1'b1;
        break;
      end
    end
    check({name, "_done"}, 32'(done), 32'd1);
  endtask

  // Link side: drives tx_ready just after each rising edge
  initial begin
    int k;
    k = 0;
    tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: tx_ready = 1'b1;
        1: tx_ready = (k % 4 == 0) || (k % 4 == 3);
        2: tx_ready = 1'($urandom_range(0, 1));
        default: tx_ready = manual_ready;
      endcase
      k++;
    end
  end

  // FIFO model, read latency 1; data is scrambled one cycle later
  initial begin
    fifo_dout = 10'h000;
    forever begin
      @(negedge clk);
      if (rst_n && fifo_rd_en) begin
        @(posedge clk);
        #1;
        check("fifo_nonempty_on_read", 32'(fifo_q.size() != 0), 32'd1);
        if (fifo_q.size() != 0) begin
          fifo_dout = fifo_q.pop_front();
          rd_total++;
        end
        @(posedge clk);
        #1;
        fifo_dout = 10'h2AA;
      end
    end
  end

  // Compare process: byte stream, handshake stability, idle rules, pkt_count
  initial begin
    bit         stall;
    logic [7:0] stall_data;
    logic [7:0] b;
    stall = 1'b0;
    stall_data = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        exp_pkt = 0;
        pos = 0;
        stall = 1'b0;
      end else begin
        if (stall) begin
          check("hold_valid", 32'(tx_valid), 32'd1);
          check("hold_data", 32'(tx_data), 32'(stall_data));
        end
        if (!busy) check("idle_valid", 32'(tx_valid), 32'd0);
        if (fifo_rd_en) begin
          check("rd_valid", 32'(tx_valid), 32'd0);
          rd_pulses++;
        end
        check("pkt_count", 32'(pkt_count), 32'(exp_pkt));
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_byte: got 0x%0h, expected no byte at %0t", tx_data, $time);
          end else begin
            b = exp_q.pop_front();
            check("byte", 32'(tx_data), 32'(b));
            pos++;
            if (pos == PKT_LEN) begin
              pos = 0;
              exp_pkt = (exp_pkt + 1) % 65536;
            end
          end
        end
        stall = tx_valid && !tx_ready;
        stall_data = tx_data;
      end
    end
  end

  initial begin
    int rd0;
    logic [9:0] a;
    logic [9:0] c;

    // 1: reset and quiet idle
    rst_n = 1'b0;
    ready_mode = 0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      check("rst_tx_valid", 32'(tx_valid), 32'd0);
      check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_pkt_count", 32'(pkt_count), 32'd0);
    end

    // 2: single packet, link always ready
    expect_literal(0);
    rd0 = rd_pulses;
    push_sample(10'h3FF);
    push_sample(10'h065);
    wait_done("pkt0");
    check("pkt0_rd_pulses", 32'(rd_pulses - rd0), 32'd2);
    check("pkt0_pkt_count", 32'(pkt_count), 32'd1);

    // 3: backpressure 1,0,0,1
    ready_mode = 1;
    expect_literal(1);
    push_sample(10'h3FF);
    push_sample(10'h065);
    wait_done("pkt1");
    check("pkt1_pkt_count", 32'(pkt_count), 32'd2);

    // 4: threshold
    ready_mode = 0;
    rd0 = rd_pulses;
    push_sample(10'h200);
    repeat (6) @(negedge clk);
    #1;
    check("thr_busy", 32'(busy), 32'd0);
    check("thr_rd_pulses", 32'(rd_pulses - rd0), 32'd0);
    expect_packet(10'h200, 10'h001);
    push_sample(10'h001);
    @(negedge clk);
    #1;
    check("thr_start_busy", 32'(busy), 32'd1);
    check("thr_start_valid", 32'(tx_valid), 32'd1);
    check("thr_start_sync", 32'(tx_data), 32'hA5);
    wait_done("thr");
    check("thr_pkt_count", 32'(pkt_count), 32'd3);

    // 5: fresh reset, then 257 packets with random backpressure
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    model_seq = 8'h00;
    check("wrap_rst_pkt_count", 32'(pkt_count), 32'd0);
    ready_mode = 2;
    for (int i = 0; i < 257; i++) begin
      a = 10'((i * 37) & 1023);
      c = 10'((i * 91 + 5) & 1023);
      expect_packet(a, c);
      push_sample(a);
      push_sample(c);
      wait_done("wrap");
    end
    check("wrap_pkt_count", 32'(pkt_count), 32'd257);

    // 6: reset while the first LO byte is waiting on the link
    ready_mode = 3;
    manual_ready = 1'b1;
    expect_packet(10'h123, 10'h2C4);
    push_sample(10'h123);
    push_sample(10'h2C4);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      #2;
      if (pos >= 3) break;
    end
    check("reach_lo", 32'(pos >= 3), 32'd1);
    manual_ready = 1'b0;
    @(negedge clk);
    #2;
    check("lo_valid", 32'(tx_valid), 32'd1);
    check("lo_data", 32'(tx_data), 32'h23);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(tx_valid), 32'd0);
    check("mid_rst_data", 32'(tx_data), 32'd0);
    check("mid_rst_rd_en", 32'(fifo_rd_en), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_pkt_count", 32'(pkt_count), 32'd0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    model_seq = 8'h00;
    ready_mode = 0;
    // 0x2C4 is still queued; one more sample completes the next packet
    expect_literal(2);
    push_sample(10'h0F0);
    wait_done("after_rst");
    check("after_rst_pkt_count", 32'(pkt_count), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
